// File: rtl/m_ext_pkg.sv
// Shared types and opcode helpers for the RV32M/RV64M execution unit.
package m_ext_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } m_opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } eng_state_e;

  function automatic logic is_div(input m_opcode_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_rem(input m_opcode_e op);
    return op inside {OpRem, OpRemu};
  endfunction

  function automatic logic is_signed_rs1(input m_opcode_e op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_rs2(input m_opcode_e op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/m_ext_iter_core.sv
// Radix-2 iterative engine: shift-add multiply or restoring divide on magnitudes.
// Result is {hi, lo}: the full product, or {remainder, quotient}.
module m_ext_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic              i_mul_div,
  input  logic [XLEN-1:0]   i_op_a,
  input  logic [XLEN-1:0]   i_op_b,
  output logic [2*XLEN-1:0] o_result,
  output logic              o_done
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic             r_run;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_opb;
  logic [XLEN:0]    w_mul_sum;
  logic [XLEN:0]    w_div_shift;
  logic [XLEN:0]    w_div_diff;
  logic             w_last;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    w_div_shift = {r_hi, r_lo[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};
  end

  assign w_last = r_run && (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_opb <= '0;
    end else if (i_flush) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_div <= i_mul_div;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= i_op_a;
      r_opb <= i_op_b;
    end else if (r_run) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_run <= 1'b0;
      if (r_div) begin
        // Borrow out of the trial subtract means the divisor did not fit: restore.
        if (!w_div_diff[XLEN]) begin
          r_hi <= w_div_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_div_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_result = {r_hi, r_lo};
  assign o_done   = w_last;

endmodule

// File: rtl/m_ext_exec_unit.sv
// M-extension execution unit: iterative MUL/DIV/REM with fast-path corner cases
// and a small result FIFO in front of the CDB broadcast arbiter.
module m_ext_exec_unit
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ROB_ADDR_W = 8,
  parameter int unsigned RESQ_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_flush,
  input  logic                            i_ex_en,
  output logic                            o_busy,
  input  logic [ROB_ADDR_W-1:0]           i_rob_addr,
  input  logic [XLEN-1:0]                 i_rs1_value,
  input  logic [XLEN-1:0]                 i_rs2_value,
  input  logic [2:0]                      i_alu_m_opcode,
  input  logic                            i_broadcast_en,
  output logic                            o_broadcast_ready,
  output logic [XLEN-1:0]                 o_broadcast_out,
  output logic [ROB_ADDR_W-1:0]           o_broadcast_rob_addr,
  output logic [$clog2(RESQ_DEPTH+1)-1:0] o_resq_count
);

  localparam int unsigned PTR_W = (RESQ_DEPTH > 1) ? $clog2(RESQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESQ_DEPTH + 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  eng_state_e            r_state;
  eng_state_e            w_state_nxt;
  m_opcode_e             r_op;
  logic [ROB_ADDR_W-1:0] r_rob;
  logic                  r_neg_p;
  logic                  r_neg_r;
  logic                  r_fast;
  logic [XLEN-1:0]       r_fast_val;

  m_opcode_e       w_op;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_val;
  logic            w_accept;
  logic            w_core_done;
  logic [2*XLEN-1:0] w_core_res;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_result;

  logic [XLEN-1:0]       r_fifo_data [RESQ_DEPTH];
  logic [ROB_ADDR_W-1:0] r_fifo_rob  [RESQ_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_full;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;

  // Issue-side decode: magnitudes for the engine, fast-path detection.
  always_comb begin
    w_op       = m_opcode_e'(i_alu_m_opcode);
    w_neg_a    = is_signed_rs1(w_op) && i_rs1_value[XLEN-1];
    w_neg_b    = is_signed_rs2(w_op) && i_rs2_value[XLEN-1];
    w_mag_a    = w_neg_a ? -i_rs1_value : i_rs1_value;
    w_mag_b    = w_neg_b ? -i_rs2_value : i_rs2_value;
    w_div_zero = is_div(w_op) && (i_rs2_value == '0);
    w_ovf      = (w_op == OpDiv || w_op == OpRem) && (i_rs1_value == MinInt) &&
                 (i_rs2_value == '1);
    w_fast     = w_div_zero || w_ovf;
    w_fast_val = '0;
    if (w_div_zero) w_fast_val = is_rem(w_op) ? i_rs1_value : '1;
    else if (w_ovf) w_fast_val = is_rem(w_op) ? '0 : MinInt;
  end

  assign w_accept = i_ex_en && !o_busy && !i_flush;

  m_ext_iter_core #(
    .XLEN (XLEN)
  ) u_iter_core (
    .clk       (clk),
    .rstn      (rstn),
    .i_start   (w_accept && !w_fast),
    .i_flush   (i_flush),
    .i_mul_div (is_div(w_op)),
    .i_op_a    (w_mag_a),
    .i_op_b    (w_mag_b),
    .o_result  (w_core_res),
    .o_done    (w_core_done)
  );

  // Sign fix-up; quotient/product follow operand signs, remainder follows the dividend.
  always_comb begin
    w_prod = r_neg_p ? -w_core_res : w_core_res;
    w_quo  = r_neg_p ? -w_core_res[XLEN-1:0] : w_core_res[XLEN-1:0];
    w_rem  = r_neg_r ? -w_core_res[2*XLEN-1:XLEN] : w_core_res[2*XLEN-1:XLEN];
    if (r_fast)              w_result = r_fast_val;
    else if (is_rem(r_op))   w_result = w_rem;
    else if (is_div(r_op))   w_result = w_quo;
    else if (r_op == OpMul)  w_result = w_prod[XLEN-1:0];
    else                     w_result = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op       <= OpMul;
      r_rob      <= '0;
      r_neg_p    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= '0;
    end else if (w_accept) begin
      r_op       <= w_op;
      r_rob      <= i_rob_addr;
      r_neg_p    <= w_neg_a ^ w_neg_b;
      r_neg_r    <= w_neg_a;
      r_fast     <= w_fast;
      r_fast_val <= w_fast_val;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = w_fast ? StDone : StCalc;
      StCalc:  if (w_core_done) w_state_nxt = StDone;
      StDone:  if (w_push) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (i_flush) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Result FIFO. A pop in the same cycle frees the slot for a push when full.
  assign w_full  = (r_count == CNT_W'(RESQ_DEPTH));
  assign w_ready = (r_count != '0);
  assign w_pop   = i_broadcast_en && w_ready && !i_flush;
  assign w_push  = (r_state == StDone) && (!w_full || w_pop) && !i_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_W'(RESQ_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(RESQ_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_result;
      r_fifo_rob[r_wptr]  <= r_rob;
    end
  end

  assign o_busy               = (r_state != StIdle) || w_full;
  assign o_broadcast_ready    = w_ready;
  assign o_broadcast_out      = w_ready ? r_fifo_data[r_rptr] : '0;
  assign o_broadcast_rob_addr = w_ready ? r_fifo_rob[r_rptr] : '0;
  assign o_resq_count         = r_count;

endmodule

// File: tb/tb_m_ext_exec_unit.sv
// Self-checking bench for m_ext_exec_unit (XLEN=32, RESQ_DEPTH=2).
module tb_m_ext_exec_unit;

  localparam int XLEN = 32;
  localparam int ROBW = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_ex_en = 1'b0;
  logic             o_busy;
  logic [ROBW-1:0]  i_rob_addr = '0;
  logic [XLEN-1:0]  i_rs1_value = '0;
  logic [XLEN-1:0]  i_rs2_value = '0;
  logic [2:0]       i_alu_m_opcode = '0;
  logic             i_broadcast_en = 1'b0;
  logic             o_broadcast_ready;
  logic [XLEN-1:0]  o_broadcast_out;
  logic [ROBW-1:0]  o_broadcast_rob_addr;
  logic [1:0]       o_resq_count;

  int errors = 0;
  int checks = 0;

  m_ext_exec_unit #(
    .XLEN       (XLEN),
    .ROB_ADDR_W (ROBW),
    .RESQ_DEPTH (2)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .i_flush              (i_flush),
    .i_ex_en              (i_ex_en),
    .o_busy               (o_busy),
    .i_rob_addr           (i_rob_addr),
    .i_rs1_value          (i_rs1_value),
    .i_rs2_value          (i_rs2_value),
    .i_alu_m_opcode       (i_alu_m_opcode),
    .i_broadcast_en       (i_broadcast_en),
    .o_broadcast_ready    (o_broadcast_ready),
    .o_broadcast_out      (o_broadcast_out),
    .o_broadcast_rob_addr (o_broadcast_rob_addr),
    .o_resq_count         (o_resq_count)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic from the RISC-V M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    if (op[2] == 1'b0) begin
      sa = (op == 3'b011) ? longint'({32'b0, a}) : longint'($signed(a));
      sb = (op == 3'b000 || op == 3'b001) ? longint'($signed(b)) : longint'({32'b0, b});
      p = 64'(sa * sb);
      return (op == 3'b000) ? p[31:0] : p[63:32];
    end
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] rob);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) check("issue_timeout", 64'(o_busy), 64'(0));
    i_alu_m_opcode = op;
    i_rs1_value    = a;
    i_rs2_value    = b;
    i_rob_addr     = rob;
    i_ex_en        = 1'b1;
    @(posedge clk);
    #1 i_ex_en = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (o_broadcast_ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic grant();
    @(negedge clk);
    i_broadcast_en = 1'b1;
    @(posedge clk);
    #1 i_broadcast_en = 1'b0;
  endtask

  task automatic wait_count(input int target);
    for (int n = 0; n < 100 && int'(o_resq_count) != target; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [7:0] rob, input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    issue(op, a, b, rob);
    wait_ready(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_out"}, 64'(o_broadcast_out), 64'(exp));
    check({tag, "_rob"}, 64'(o_broadcast_rob_addr), 64'(rob));
    grant();
    check({tag, "_drain"}, 64'(o_broadcast_ready), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;

    #17 rstn = 1'b0;
    check("rst_ready", 64'(o_broadcast_ready), 64'(0));
    check("rst_busy",  64'(o_busy), 64'(0));
    check("rst_out",   64'(o_broadcast_out), 64'(0));
    check("rst_rob",   64'(o_broadcast_rob_addr), 64'(0));
    check("rst_count", 64'(o_resq_count), 64'(0));
    @(negedge clk) rstn = 1'b1;

    // Directed values from the specification.
    run_op("mul",    3'b000, 32'd3, 32'd5, 8'd1, 32'h0000_000F, 33);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd2, 32'h0000_0000, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd3, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 8'd4, 32'hFFFF_FFFF, 33);
    run_op("div",    3'b100, -32'sd7, 32'd2, 8'd5, 32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, -32'sd7, 32'd2, 8'd6, 32'hFFFF_FFFF, 33);
    run_op("divu",   3'b101, 32'd100, 32'd7, 8'd7, 32'h0000_000E, 33);
    run_op("remu",   3'b111, 32'd100, 32'd7, 8'd8, 32'h0000_0002, 33);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 8'd9, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 8'd10, 32'h0, 1);
    run_op("divu_z", 3'b101, 32'd7, 32'd0, 8'd11, 32'hFFFF_FFFF, 1);
    run_op("remu_z", 3'b111, 32'd7, 32'd0, 8'd12, 32'h7, 1);

    // Randomized ops, biased toward corner operands.
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'($urandom_range(1, 9))
            : $urandom;
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 8'(i + 32), ref_model(op, a, b),
             ref_latency(op, a, b));
    end

    // Back-pressure: two buffered results make the unit busy.
    issue(3'b000, 32'd6, 32'd7, 8'd1);
    wait_count(1);
    issue(3'b000, 32'd9, 32'd9, 8'd2);
    wait_count(2);
    check("bp_count2", 64'(o_resq_count), 64'(2));
    check("bp_busy",   64'(o_busy), 64'(1));
    @(negedge clk);
    i_alu_m_opcode = 3'b101; i_rs1_value = 32'd100; i_rs2_value = 32'd7;
    i_rob_addr = 8'd3; i_ex_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("bp_held_busy",  64'(o_busy), 64'(1));
    check("bp_held_count", 64'(o_resq_count), 64'(2));
    @(negedge clk) i_ex_en = 1'b0;
    check("bp_head1_rob", 64'(o_broadcast_rob_addr), 64'(1));
    check("bp_head1_out", 64'(o_broadcast_out), 64'(42));
    grant();
    check("bp_head2_rob", 64'(o_broadcast_rob_addr), 64'(2));
    check("bp_count1",    64'(o_resq_count), 64'(1));
    issue(3'b101, 32'd100, 32'd7, 8'd3);
    repeat (XLEN) @(posedge clk);
    #1 check("bp_pre_push_count", 64'(o_resq_count), 64'(1));
    @(negedge clk) i_broadcast_en = 1'b1;
    @(posedge clk);
    #1 i_broadcast_en = 1'b0;
    check("bp_pushpop_count", 64'(o_resq_count), 64'(1));
    check("bp_head3_rob",     64'(o_broadcast_rob_addr), 64'(3));
    check("bp_head3_out",     64'(o_broadcast_out), 64'(14));
    grant();
    check("bp_empty", 64'(o_resq_count), 64'(0));

    // Empty pop is ignored.
    grant();
    check("empty_pop_count", 64'(o_resq_count), 64'(0));
    check("empty_pop_ready", 64'(o_broadcast_ready), 64'(0));

    // Flush with one buffered result and one op in CALC.
    issue(3'b000, 32'd6, 32'd7, 8'd7);
    wait_count(1);
    issue(3'b100, 32'd1000, 32'd3, 8'd8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1; i_broadcast_en = 1'b1; i_ex_en = 1'b1; i_rob_addr = 8'd9;
    @(posedge clk);
    #1 begin i_flush = 1'b0; i_broadcast_en = 1'b0; i_ex_en = 1'b0; end
    check("flush_ready", 64'(o_broadcast_ready), 64'(0));
    check("flush_busy",  64'(o_busy), 64'(0));
    check("flush_count", 64'(o_resq_count), 64'(0));
    repeat (40) @(posedge clk);
    #1 check("flush_no_stale", 64'(o_resq_count), 64'(0));
    run_op("post_flush", 3'b000, 32'd2, 32'd2, 8'd5, 32'd4, 33);
    check("post_flush_count", 64'(o_resq_count), 64'(0));

    // Asynchronous reset mid-operation.
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 8'd20);
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("rst_mid_busy",  64'(o_busy), 64'(0));
    check("rst_mid_count", 64'(o_resq_count), 64'(0));
    check("rst_mid_ready", 64'(o_broadcast_ready), 64'(0));
    @(negedge clk) rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("rst_mid_no_result", 64'(o_broadcast_ready), 64'(0));
    run_op("post_reset", 3'b110, 32'd17, -32'sd5, 8'd21, 32'd2, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
